// File: rtl/sha512_pkg.sv
// Shared types and constants for the SHA-512 message padder.
package sha512_pkg;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_PAD,
        ST_LEN,
        ST_EMIT
    } state_e;

    localparam int unsigned SHA512_BLOCK_WORDS  = 16;
    localparam int unsigned SHA512_LEN_WORD_IDX = 14;
    localparam logic [63:0] SHA512_PAD_WORD     = 64'h8000_0000_0000_0000;

endpackage

// File: rtl/sha512_last_word_mask.sv
// Last-word formatting: keeps bytes below the valid count, inserts 0x80 after
// them and zeroes the rest. Counts above 8 are clamped to 8.
module sha512_last_word_mask (
    input  logic [63:0] data_i,
    input  logic [3:0]  bytes_i,
    output logic [63:0] word_o,
    output logic [3:0]  nbytes_o,
    output logic        full_o
);

    always_comb begin
        nbytes_o = (bytes_i > 4'd8) ? 4'd8 : bytes_i;
        full_o   = (nbytes_o == 4'd8);
        word_o   = '0;
        for (int unsigned b = 0; b < 8; b++) begin
            if (b < 32'(nbytes_o)) begin
                word_o[63 - 8*b -: 8] = data_i[63 - 8*b -: 8];
            end else if (b == 32'(nbytes_o)) begin
                word_o[63 - 8*b -: 8] = 8'h80;
            end
        end
    end

endmodule

// File: rtl/sha512_padder.sv
// SHA-512 message padder: packs 64-bit big-endian words into 1024-bit blocks
// and appends the 0x80 marker, zero fill and 128-bit bit length.
module sha512_padder
    import sha512_pkg::*;
#(
    parameter int unsigned DataWidth  = 64,
    parameter int unsigned BlockWidth = 1024,
    parameter int unsigned LenWidth   = 128
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DataWidth-1:0]  data_i,
    input  logic                  valid_i,
    input  logic                  last_i,
    input  logic [3:0]            bytes_i,
    output logic                  ready_o,
    output logic [BlockWidth-1:0] block_o,
    output logic                  block_valid_o,
    output logic                  block_first_o,
    output logic                  block_last_o,
    input  logic                  block_ready_i
);

    state_e               state_q, state_d;
    logic [3:0]           widx_q, widx_d;
    logic [LenWidth-1:0]  bitlen_q, bitlen_d;
    logic                 pad_pending_q, pad_pending_d;
    logic                 first_q, first_d;
    logic                 final_q, final_d;
    logic                 last_seen_q, last_seen_d;
    logic [DataWidth-1:0] buf_q [SHA512_BLOCK_WORDS];
    logic [DataWidth-1:0] buf_d [SHA512_BLOCK_WORDS];

    logic                 wr_en;
    logic [DataWidth-1:0] wr_word;
    logic [63:0]          mask_word;
    logic [3:0]           mask_nbytes;
    logic                 mask_full;
    logic [127:0]         len_field;

    sha512_last_word_mask u_mask (
        .data_i   (data_i),
        .bytes_i  (bytes_i),
        .word_o   (mask_word),
        .nbytes_o (mask_nbytes),
        .full_o   (mask_full)
    );

    assign len_field = 128'(bitlen_q);

    always_comb begin
        state_d       = state_q;
        widx_d        = widx_q;
        bitlen_d      = bitlen_q;
        pad_pending_d = pad_pending_q;
        first_d       = first_q;
        final_d       = final_q;
        last_seen_d   = last_seen_q;
        buf_d         = buf_q;
        wr_en         = 1'b0;
        wr_word       = '0;

        unique case (state_q)
            ST_FILL: begin
                if (valid_i) begin
                    wr_en = 1'b1;
                    if (last_i) begin
                        wr_word       = mask_word;
                        bitlen_d      = bitlen_q + LenWidth'({mask_nbytes, 3'b000});
                        pad_pending_d = mask_full;
                        last_seen_d   = 1'b1;
                    end else begin
                        wr_word  = data_i;
                        bitlen_d = bitlen_q + LenWidth'(DataWidth);
                    end
                end
            end
            ST_PAD: begin
                wr_en = 1'b1;
                if (pad_pending_q) begin
                    wr_word       = SHA512_PAD_WORD;
                    pad_pending_d = 1'b0;
                end
            end
            ST_LEN: begin
                buf_d[SHA512_LEN_WORD_IDX]     = len_field[127:64];
                buf_d[SHA512_LEN_WORD_IDX + 1] = len_field[63:0];
                final_d                        = 1'b1;
                state_d                        = ST_EMIT;
            end
            ST_EMIT: begin
                if (block_ready_i) begin
                    widx_d  = '0;
                    first_d = 1'b0;
                    if (final_q) begin
                        bitlen_d    = '0;
                        first_d     = 1'b1;
                        final_d     = 1'b0;
                        last_seen_d = 1'b0;
                        state_d     = ST_FILL;
                    end else begin
                        state_d = last_seen_q ? ST_PAD : ST_FILL;
                    end
                end
            end
            default: state_d = ST_FILL;
        endcase

        // Shared word write and routing for FILL and PAD; the decision uses the
        // post-write flags so a last word landing at index 13 goes straight to LEN.
        if (wr_en) begin
            buf_d[widx_q] = wr_word;
            widx_d        = widx_q + 4'd1;
            if (widx_q == 4'd15) begin
                state_d = ST_EMIT;
            end else if (last_seen_d && widx_d == 4'(SHA512_LEN_WORD_IDX) && !pad_pending_d) begin
                state_d = ST_LEN;
            end else if (last_seen_d) begin
                state_d = ST_PAD;
            end else begin
                state_d = ST_FILL;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_FILL;
            widx_q        <= '0;
            bitlen_q      <= '0;
            pad_pending_q <= 1'b0;
            first_q       <= 1'b1;
            final_q       <= 1'b0;
            last_seen_q   <= 1'b0;
            for (int unsigned i = 0; i < SHA512_BLOCK_WORDS; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            widx_q        <= widx_d;
            bitlen_q      <= bitlen_d;
            pad_pending_q <= pad_pending_d;
            first_q       <= first_d;
            final_q       <= final_d;
            last_seen_q   <= last_seen_d;
            for (int unsigned i = 0; i < SHA512_BLOCK_WORDS; i++) begin
                buf_q[i] <= buf_d[i];
            end
        end
    end

    always_comb begin
        block_o = '0;
        for (int unsigned w = 0; w < SHA512_BLOCK_WORDS; w++) begin
            block_o[BlockWidth - 1 - DataWidth*w -: DataWidth] = buf_q[w];
        end
    end

    assign ready_o       = (state_q == ST_FILL);
    assign block_valid_o = (state_q == ST_EMIT);
    assign block_first_o = block_valid_o & first_q;
    assign block_last_o  = block_valid_o & final_q;

endmodule

// File: doc/sha512_padder.md
# sha512_padder

Upstream message-formatting stage for the SHA-512 accelerator. Accepts a message as a stream of 64-bit big-endian words and emits complete 1024-bit padded blocks to the SHA-512 block path. Padding follows FIPS 180-4: a 0x80 byte after the message, zero fill, and a 128-bit big-endian bit length. Blocks carry first/last flags so the consumer can reinitialise the hash state and identify the final digest.

## Interface

Parameters:
- DataWidth, 64, input word width; only 64 is supported.
- BlockWidth, 1024, output block width; only 1024 is supported.
- LenWidth, 128, width of the message bit-length counter and length field.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- data_i  in  DataWidth  message word; byte 0 is data_i[63:56].
- valid_i  in  1  data_i is valid.
- last_i  in  1  word is the final word of the message.
- bytes_i  in  4  valid bytes in the final word, 0..8; only sampled with last_i. Values 9..15 are treated as 8.
- ready_o  out  1  padder accepts a word this cycle.
- block_o  out  BlockWidth  padded block; word 0 is block_o[1023:960].
- block_valid_o  out  1  block_o is valid.
- block_first_o  out  1  block is the first block of a message.
- block_last_o  out  1  block is the final block; it carries the length field.
- block_ready_i  in  1  consumer takes the block.

## Operation

- Buffer of 16 × 64-bit words with write index widx (0..15).
- Control registers:
  - bitlen: LenWidth bits, wraps modulo 2^128.
  - pad_pending: the 0x80 word is still owed.
  - first: the next emitted block is the first of its message.
  - final: the current block is the final block.
- FSM states: FILL, PAD, LEN, EMIT.
- FILL (ready_o=1):
  - On valid_i & ~last_i: write data_i at widx, widx++, bitlen += 64.
  - On valid_i & last_i with n = bytes_i: write data_i with bytes ≥ n zeroed; if n<8, byte n = 0x80; bitlen += 8n; if n==8, set pad_pending.
- PAD: one word per cycle at widx. Write 0x8000_0000_0000_0000 if pad_pending (then clear it), otherwise zero.
- Next state after any write in FILL or PAD:
  - EMIT (final=0) if the written widx was 15.
  - Else LEN if the last word has been seen, the new widx is 14, and pad_pending is clear.
  - Else PAD if the last word has been seen.
  - Else FILL.
- LEN: write bitlen[127:64] at word 14 and bitlen[63:0] at word 15, set final, go to EMIT.
- EMIT: block_valid_o=1. On block_ready_i:
  - widx=0 and first=0.
  - If final: clear bitlen, set first=1, go to FILL.
  - Else: go to FILL if the last word has not been seen, otherwise PAD.
- The buffer is zero-written by PAD, so no unmasked stale data reaches block_o.

## Timing

- Reset values:
  - ready_o=1 (state FILL), block_valid_o=0, block_first_o=0, block_last_o=0, block_o=0.
  - widx=0, bitlen=0, pad_pending=0, first=1.
- ready_o is high only in FILL. It is a registered function of state and does not depend on valid_i.
- Handshakes:
  - Input transfers when valid_i & ready_o.
  - Output transfers when block_valid_o & block_ready_i.
  - block_o and the flags stay stable while block_valid_o=1 and block_ready_i=0.
- block_first_o and block_last_o are valid only with block_valid_o. A single-block message asserts both.
- Latency:
  - A full 16-word fill drives block_valid_o high in the cycle after the 16th accept.
  - For last accepted at widx=k (no pad_pending), block_valid_o rises at cycle t + (13−k) + 2.
  - Example: "abc" at k=0 gives t+15.
- Minimum throughput: one cycle per word, plus one EMIT cycle per block when block_ready_i is held high.
- Reset asserted mid-message or mid-EMIT discards all state and returns to reset values on the next edge.

## Structure

- Package sha512_pkg holds:
  - the state enum;
  - constants SHA512_BLOCK_WORDS=16, SHA512_LEN_WORD_IDX=14, SHA512_PAD_WORD=64'h8000_0000_0000_0000.
- One sub-module, sha512_last_word_mask: combinational byte masking and 0x80 insertion for the last word from data_i and bytes_i.
- Everything else (FSM, buffer, counters) lives in sha512_padder.

## Test plan

- **"abc":** word 0x6162_6300_0000_0000, last, bytes=3.
  - One block: word0=0x6162_6380_0000_0000, words1..14=0, word15=0x18.
  - first=last=1; block_valid_o rises at t+15.
- **Empty message:** last, bytes=0.
  - One block: word0=0x8000…0, word15=0.
  - first=last=1.
- **111 bytes** (13 full words plus a last word with bytes=7):
  - One block with byte 7 of word13 = 0x80.
  - word15=0x378, word14=0.
- **112 bytes** (14 full words, last with bytes=8):
  - Block 1: word14=0x8000…0, word15=0, first=1, last=0.
  - Block 2: all zero except word15=0x380, first=0, last=1.
- **Backpressure:** block_ready_i low for 10 cycles on a full 16-word block.
  - block_o and flags stay constant, ready_o=0 throughout.
  - The next message starts accepting one cycle after the handshake.
- **Reset mid-message:** accept 5 words, then pulse rst_i.
  - All outputs return to reset values.
  - A following "abc" message produces the exact "abc" block with first=1.
